// File: rtl/reco_job_ctrl.sv
// reco_job_ctrl
//   Runs one recorrelation job through an external 2-state recorrelator. That
//   recorrelator has no enable input, so any cycle without an accepted pair
//   feeds it (0,0). A (0,0) pair leaves its state unchanged and produces a
//   (0,0) output, so input stalls have no effect on the job result.
//   Per job: clear the recorrelator, stream len pairs, drain its output
//   register, then publish the ones-counts and the unpaired residue.
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   start, len            job request and length (sampled only in IDLE)
//   abort                 synchronous cancel in CLEAR/RUN/DRAIN, no done pulse
//   in_valid, in_ready    pair handshake; x_in/y_in are the source bits
//   reco_rst_n            registered active-low reset to the recorrelator
//   reco_x, reco_y        bits fed to the recorrelator (0 unless accepting)
//   reco_xo, reco_yo      registered recorrelator outputs
//   busy, done            state != IDLE; 1-cycle results-valid pulse
//   in_cnt_*, out_cnt_*   ones counted at the input / output of the job
//   resid_x, resid_y      a bit was lost unpaired on that channel
module reco_job_ctrl #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x_in,
    input  logic             y_in,
    output logic             reco_rst_n,
    output logic             reco_x,
    output logic             reco_y,
    input  logic             reco_xo,
    input  logic             reco_yo,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] in_cnt_x,
    output logic [LEN_W-1:0] in_cnt_y,
    output logic [LEN_W-1:0] out_cnt_x,
    output logic [LEN_W-1:0] out_cnt_y,
    output logic             resid_x,
    output logic             resid_y
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             acc_q, acc_d;
    logic             reco_rst_n_q, reco_rst_n_d;
    // working counters for the job in flight
    logic [LEN_W-1:0] w_in_x_q, w_in_x_d, w_in_y_q, w_in_y_d;
    logic [LEN_W-1:0] w_out_x_q, w_out_x_d, w_out_y_q, w_out_y_d;
    // published results, held until the next done
    logic [LEN_W-1:0] r_in_x_q, r_in_x_d, r_in_y_q, r_in_y_d;
    logic [LEN_W-1:0] r_out_x_q, r_out_x_d, r_out_y_q, r_out_y_d;
    logic             resid_x_q, resid_x_d, resid_y_q, resid_y_d;
    logic             accept;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid & in_ready;
    assign reco_x   = accept & x_in;
    assign reco_y   = accept & y_in;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        w_in_x_d  = w_in_x_q;
        w_in_y_d  = w_in_y_q;
        w_out_x_d = w_out_x_q;
        w_out_y_d = w_out_y_q;
        r_in_x_d  = r_in_x_q;
        r_in_y_d  = r_in_y_q;
        r_out_x_d = r_out_x_q;
        r_out_y_d = r_out_y_q;
        resid_x_d = resid_x_q;
        resid_y_d = resid_y_q;

        if (accept & x_in) w_in_x_d = w_in_x_q + LEN_W'(1);
        if (accept & y_in) w_in_y_d = w_in_y_q + LEN_W'(1);
        // acc_q marks the cycle where the recorrelator output reflects an accepted pair
        if (acc_q & reco_xo) w_out_x_d = w_out_x_q + LEN_W'(1);
        if (acc_q & reco_yo) w_out_y_d = w_out_y_q + LEN_W'(1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d   = DONE;
                        w_in_x_d  = '0;
                        w_in_y_d  = '0;
                        w_out_x_d = '0;
                        w_out_y_d = '0;
                    end else begin
                        state_d = CLEAR;
                        rem_d   = len;
                    end
                end
            end
            CLEAR: begin
                state_d   = RUN;
                w_in_x_d  = '0;
                w_in_y_d  = '0;
                w_out_x_d = '0;
                w_out_y_d = '0;
            end
            RUN: begin
                if (accept) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // abort outranks every transition, including the last accept
        if (abort && (state_q == CLEAR || state_q == RUN || state_q == DRAIN))
            state_d = IDLE;

        // results load on entry to DONE so they are already valid while done=1
        if (state_d == DONE) begin
            r_in_x_d  = w_in_x_d;
            r_in_y_d  = w_in_y_d;
            r_out_x_d = w_out_x_d;
            r_out_y_d = w_out_y_d;
            resid_x_d = (w_in_x_d != w_out_x_d);
            resid_y_d = (w_in_y_d != w_out_y_d);
        end
    end

    assign acc_d        = accept & ~abort;
    assign reco_rst_n_d = (state_d != CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            acc_q        <= 1'b0;
            reco_rst_n_q <= 1'b0;
            w_in_x_q     <= '0;
            w_in_y_q     <= '0;
            w_out_x_q    <= '0;
            w_out_y_q    <= '0;
            r_in_x_q     <= '0;
            r_in_y_q     <= '0;
            r_out_x_q    <= '0;
            r_out_y_q    <= '0;
            resid_x_q    <= 1'b0;
            resid_y_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            acc_q        <= acc_d;
            reco_rst_n_q <= reco_rst_n_d;
            w_in_x_q     <= w_in_x_d;
            w_in_y_q     <= w_in_y_d;
            w_out_x_q    <= w_out_x_d;
            w_out_y_q    <= w_out_y_d;
            r_in_x_q     <= r_in_x_d;
            r_in_y_q     <= r_in_y_d;
            r_out_x_q    <= r_out_x_d;
            r_out_y_q    <= r_out_y_d;
            resid_x_q    <= resid_x_d;
            resid_y_q    <= resid_y_d;
        end
    end

    assign reco_rst_n = reco_rst_n_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign in_cnt_x   = r_in_x_q;
    assign in_cnt_y   = r_in_y_q;
    assign out_cnt_x  = r_out_x_q;
    assign out_cnt_y  = r_out_y_q;
    assign resid_x    = resid_x_q;
    assign resid_y    = resid_y_q;

endmodule

// File: tb/tb_reco_job_ctrl.sv
// Directed bench for reco_job_ctrl with a behavioural 2-state recorrelator.
// Cycle numbering: the cycle in which start is seen in IDLE is cycle 0.
module tb_reco_job_ctrl;
    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic             x_in = 1'b0, y_in = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_ready, reco_rst_n, reco_x, reco_y, busy, done;
    logic             resid_x, resid_y;
    logic [LEN_W-1:0] in_cnt_x, in_cnt_y, out_cnt_x, out_cnt_y;
    logic             reco_xo, reco_yo, rs;
    int               total = 0, bad = 0;
    int               lat, rlow;

    always #5 clk = ~clk;

    reco_job_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
        .reco_rst_n(reco_rst_n), .reco_x(reco_x), .reco_y(reco_y),
        .reco_xo(reco_xo), .reco_yo(reco_yo), .busy(busy), .done(done),
        .in_cnt_x(in_cnt_x), .in_cnt_y(in_cnt_y), .out_cnt_x(out_cnt_x),
        .out_cnt_y(out_cnt_y), .resid_x(resid_x), .resid_y(resid_y)
    );

    // External recorrelator: a lone x=1 is held (state rs) until a lone y=1
    // pairs with it, then both come out together. Equal pairs pass through.
    always @(posedge clk or negedge reco_rst_n) begin
        if (!reco_rst_n) begin
            rs <= 1'b0; reco_xo <= 1'b0; reco_yo <= 1'b0;
        end else if (reco_x == reco_y) begin
            reco_xo <= reco_x; reco_yo <= reco_y;
        end else if (reco_x) begin
            if (!rs) begin rs <= 1'b1; reco_xo <= 1'b0; reco_yo <= 1'b0; end
            else begin reco_xo <= 1'b1; reco_yo <= 1'b0; end
        end else begin
            if (rs) begin rs <= 1'b0; reco_xo <= 1'b1; reco_yo <= 1'b1; end
            else begin reco_xo <= 1'b0; reco_yo <= 1'b1; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string t, input int ix, iy, ox, oy, input logic rx, ry);
        chk({t, " in_cnt_x"}, 32'(in_cnt_x), ix);
        chk({t, " in_cnt_y"}, 32'(in_cnt_y), iy);
        chk({t, " out_cnt_x"}, 32'(out_cnt_x), ox);
        chk({t, " out_cnt_y"}, 32'(out_cnt_y), oy);
        chk({t, " resid_x"}, 32'(resid_x), 32'(rx));
        chk({t, " resid_y"}, 32'(resid_y), 32'(ry));
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, " busy"}, 32'(busy), 0);
        chk({t, " done"}, 32'(done), 0);
        chk({t, " in_ready"}, 32'(in_ready), 0);
        chk({t, " reco_rst_n"}, 32'(reco_rst_n), 0);
        chk_res(t, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Runs one job MSB-first. Outside RUN it drives in_valid=1 with ones so that
    // the bench sees they are ignored. A second start is pushed after pair 0 to
    // show it is ignored while busy. Returns done's cycle (-1 if never) and the
    // number of cycles reco_rst_n was low. Ends at the done cycle, #1 past negedge.
    task automatic run_job(input string t, input int n, input logic [15:0] xv, yv,
                           input int gap_at, gap_n, abort_at,
                           output int lat_o, output int rlow_o);
        int idx = 0, gapc = 0, cyc = 0;
        logic acc;
        lat_o = -1; rlow_o = 0;
        @(negedge clk); start = 1'b1; len = LEN_W'(n); in_valid = 1'b0;
        do begin
            @(negedge clk); cyc++; start = 1'b0; abort = 1'b0;
            if (done) lat_o = cyc;
            if (!reco_rst_n) rlow_o++;
            if (in_ready) begin
                if (idx == gap_at && gapc < gap_n) begin
                    in_valid = 1'b0; x_in = 1'b1; y_in = 1'b1; gapc++;
                end else begin
                    in_valid = 1'b1; x_in = xv[n-1-idx]; y_in = yv[n-1-idx];
                    if (idx == 1) begin start = 1'b1; len = 10'd9; end
                    if (idx == abort_at) abort = 1'b1;
                    idx++;
                end
            end else begin
                in_valid = 1'b1; x_in = 1'b1; y_in = 1'b1;
            end
            #1;
            acc = in_valid & in_ready;
            chk({t, " reco_x"}, 32'(reco_x), acc ? 32'(x_in) : 0);
            chk({t, " reco_y"}, 32'(reco_y), acc ? 32'(y_in) : 0);
        end while (lat_o < 0 && cyc < n + gap_n + 6);
        in_valid = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic after_done(input string t);
        @(negedge clk); #1;
        chk({t, " done pulse 1 cycle"}, 32'(done), 0);
        chk({t, " busy after"}, 32'(busy), 0);
    endtask

    initial begin
        #12; chk_reset_vals("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle reco_rst_n", 32'(reco_rst_n), 1);

        // 1: all-ones, start cycle 0 -> done at len+3 = 7
        run_job("t1", 4, 16'b1111, 16'b1111, -1, 0, -1, lat, rlow);
        chk("t1 latency", lat, 7); chk("t1 clear pulse", rlow, 1);
        chk_res("t1", 4, 4, 4, 4, 1'b0, 1'b0);
        after_done("t1");

        // 2: alternating lone bits pair up -> 2/2 in and out
        run_job("t2", 4, 16'b1010, 16'b0101, -1, 0, -1, lat, rlow);
        chk("t2 latency", lat, 7);
        chk_res("t2", 2, 2, 2, 2, 1'b0, 1'b0);
        after_done("t2");

        // 3: lone x bit stays trapped in the recorrelator
        run_job("t3", 3, 16'b100, 16'b000, -1, 0, -1, lat, rlow);
        chk("t3 latency", lat, 6);
        chk_res("t3", 1, 0, 0, 0, 1'b1, 1'b0);
        after_done("t3");

        // 5: zero-length job -> done next cycle, no clear pulse
        run_job("t5", 0, 16'b0, 16'b0, -1, 0, -1, lat, rlow);
        chk("t5 latency", lat, 1); chk("t5 clear pulse", rlow, 0);
        chk_res("t5", 0, 0, 0, 0, 1'b0, 1'b0);
        after_done("t5");

        // 4: test 1 with a 3-cycle stall after pair 2
        run_job("t4", 4, 16'b1111, 16'b1111, 2, 3, -1, lat, rlow);
        chk("t4 latency", lat, 10);
        chk_res("t4", 4, 4, 4, 4, 1'b0, 1'b0);
        after_done("t4");

        // 6a: abort together with the last accept after 2 pairs -> no done
        run_job("t6", 3, 16'b111, 16'b111, -1, 0, 2, lat, rlow);
        chk("t6 no done", lat, -1);
        chk("t6 busy", 32'(busy), 0);
        chk_res("t6 held", 4, 4, 4, 4, 1'b0, 1'b0);

        // 6b: reset in the middle of RUN
        @(negedge clk); start = 1'b1; len = 10'd4;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; x_in = 1'b1; y_in = 1'b1;
        @(negedge clk); #1;
        chk("t6b in RUN", 32'(in_ready), 1);
        @(negedge clk); rst_n = 1'b0; #1;
        chk_reset_vals("t6b reset");
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk); #1;
        chk("t6b reco_rst_n released", 32'(reco_rst_n), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
